// File: rtl/adc_pkg.sv
// Shared constants and state type for the serial ADC front-end.
package adc_pkg;

    localparam int unsigned LEAD_BITS  = 4;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_BITS;
    // Bit counter must hold 0..FRAME_BITS inclusive.
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        WAIT
    } adc_state_e;

endpackage

// File: rtl/prueba_adc_if.sv
// Pin-level bundle between the ADC front-end (master) and the ADC/consumer side (slave).
interface prueba_adc_if;

    logic                           data_ADC;
    logic                           start;
    logic                           done;
    logic                           CS;
    logic                           Clock_Muestreo;
    logic [adc_pkg::LEAD_BITS-1:0]  data_basura;
    logic [adc_pkg::DATA_BITS-1:0]  Dato;

    modport master (
        input  data_ADC,
        input  start,
        output done,
        output CS,
        output Clock_Muestreo,
        output data_basura,
        output Dato
    );

    modport slave (
        output data_ADC,
        output start,
        input  done,
        input  CS,
        input  Clock_Muestreo,
        input  data_basura,
        input  Dato
    );

endinterface

// File: rtl/adc_sclk_div.sv
// Free-running divider that generates the ADC serial clock plus single-cycle
// enables flagging the system cycle at whose end the serial clock toggles.
module adc_sclk_div #(
    parameter int unsigned HALF_PERIOD = 5
) (
    input  logic Clock_Nexys,
    input  logic reset_Clck,
    output logic Clock_Muestreo,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int unsigned   CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap      = (cnt_q == LAST);
    assign sclk_rise = wrap & ~Clock_Muestreo;
    assign sclk_fall = wrap & Clock_Muestreo;

    // Count HALF_PERIOD system cycles per half period, then toggle the serial clock.
    always_ff @(posedge Clock_Nexys or negedge reset_Clck) begin
        if (!reset_Clck) begin
            cnt_q          <= '0;
            Clock_Muestreo <= 1'b0;
        end else if (wrap) begin
            cnt_q          <= '0;
            Clock_Muestreo <= ~Clock_Muestreo;
        end else begin
            cnt_q          <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/prueba_adc.sv
// Serial front-end for a 12-bit SPI-style ADC: frames 16 SCLK cycles with CS,
// shifts in 4 leading bits plus 12 data bits MSB first, then publishes the sample.
module prueba_adc
    import adc_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 5
) (
    input  logic         Clock_Nexys,
    input  logic         Reset,
    input  logic         reset_Clck,
    prueba_adc_if.master adc
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic sclk;
    logic sclk_rise;
    logic sclk_fall;

    adc_sclk_div #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_div (
        .Clock_Nexys    (Clock_Nexys),
        .reset_Clck     (reset_Clck),
        .Clock_Muestreo (sclk),
        .sclk_rise      (sclk_rise),
        .sclk_fall      (sclk_fall)
    );

    adc_state_e              state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [FRAME_BITS-1:0]   sr_q;
    logic                    cs_q;
    logic                    done_q;
    logic [LEAD_BITS-1:0]    basura_q;
    logic [DATA_BITS-1:0]    dato_q;

    // Conversion FSM: frame alignment, bit capture and registered outputs.
    always_ff @(posedge Clock_Nexys or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
            basura_q  <= '0;
            dato_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Drop CS only while SCLK is low and not about to rise.
                    if (adc.start && !sclk && !sclk_rise) begin
                        cs_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        sr_q      <= {sr_q[FRAME_BITS-2:0], adc.data_ADC};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (sclk_fall) begin
                        cs_q     <= 1'b1;
                        basura_q <= sr_q[FRAME_BITS-1:DATA_BITS];
                        dato_q   <= sr_q[DATA_BITS-1:0];
                        done_q   <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    // Quiet time: CS stays high from one SCLK fall to the next.
                    if (sclk_fall) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc.Clock_Muestreo = sclk;
    assign adc.CS             = cs_q;
    assign adc.done           = done_q;
    assign adc.data_basura    = basura_q;
    assign adc.Dato           = dato_q;

endmodule

// File: tb/tb_prueba_adc.sv
// Self-checking bench for prueba_adc: an ADC-side monitor/driver models the frame
// protocol and checks every cycle; directed frames pin the model with literals.
module tb_prueba_adc;

    localparam int unsigned HP = 5;

    logic Clock_Nexys = 1'b0;
    logic Reset;
    logic reset_Clck;

    prueba_adc_if bus ();

    prueba_adc #(
        .HALF_PERIOD (HP)
    ) dut (
        .Clock_Nexys (Clock_Nexys),
        .Reset       (Reset),
        .reset_Clck  (reset_Clck),
        .adc         (bus)
    );

    always #5 Clock_Nexys = ~Clock_Nexys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [15:0] tx_q[$];
    logic [15:0] cur_word;
    logic [15:0] collected;
    logic [11:0] exp_dato;
    logic [3:0]  exp_basura;
    logic        mon_en = 1'b0;
    logic        sclk_prev;
    logic        in_frame;
    logic        pending;
    logic        rise;
    logic        fall;
    logic        exp_done;
    int          n_clk;
    int          cyc;
    int          cs_rise_cyc;
    int          rises;
    int          done_cnt;

    // ADC-side model: drives data_ADC, tracks expected outputs, compares every cycle.
    initial begin
        bus.data_ADC = 1'b0;
        sclk_prev    = 1'b0;
        in_frame     = 1'b0;
        pending      = 1'b0;
        exp_dato     = '0;
        exp_basura   = '0;
        collected    = '0;
        cur_word     = '0;
        n_clk        = 0;
        cyc          = 0;
        cs_rise_cyc  = -1000;
        rises        = 0;
        done_cnt     = 0;
        forever begin
            @(posedge Clock_Nexys);
            #1;
            cyc++;
            if (reset_Clck) n_clk++;
            else n_clk = 0;
            if (mon_en) begin
                chk("sclk_wave", bus.Clock_Muestreo, ((n_clk / HP) % 2) == 1);
                rise = bus.Clock_Muestreo && !sclk_prev;
                fall = !bus.Clock_Muestreo && sclk_prev;
                if (!Reset) begin
                    chk("rst_cs", bus.CS, 1'b1);
                    chk("rst_done", bus.done, 1'b0);
                    chk("rst_dato", bus.Dato, 12'h000);
                    chk("rst_basura", bus.data_basura, 4'h0);
                    exp_dato   = '0;
                    exp_basura = '0;
                    in_frame   = 1'b0;
                    pending    = 1'b0;
                    rises      = 0;
                end else begin
                    exp_done = pending && fall;
                    chk("done", bus.done, exp_done);
                    if (bus.done) done_cnt++;
                    if (exp_done) begin
                        chk("cs_rise_at_done", bus.CS, 1'b1);
                        exp_basura  = collected[15:12];
                        exp_dato    = collected[11:0];
                        pending     = 1'b0;
                        in_frame    = 1'b0;
                        cs_rise_cyc = cyc;
                    end
                    chk("dato", bus.Dato, exp_dato);
                    chk("basura", bus.data_basura, exp_basura);
                    if (!exp_done && !in_frame && !bus.CS) begin
                        chk("cs_fall_sclk_low", bus.Clock_Muestreo, 1'b0);
                        chk("cs_gap", (cyc - cs_rise_cyc) >= 2 * HP, 1'b1);
                        in_frame     = 1'b1;
                        rises        = 0;
                        collected    = '0;
                        cur_word     = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0000;
                        bus.data_ADC = cur_word[15];
                    end else if (in_frame) begin
                        chk("cs_low_in_frame", bus.CS, 1'b0);
                        if (rise) begin
                            chk("rises_le_16", rises < 16, 1'b1);
                            collected = {collected[14:0], bus.data_ADC};
                            rises++;
                            if (rises == 16) pending = 1'b1;
                        end
                        if (fall && rises < 16) bus.data_ADC = cur_word[15-rises];
                    end
                end
            end
            sclk_prev = bus.Clock_Muestreo;
        end
    end

    task automatic wait_sclk_fall();
        logic p;
        bit   ok;
        p  = bus.Clock_Muestreo;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock_Nexys);
            #1;
            if (p && !bus.Clock_Muestreo) begin
                ok = 1'b1;
                break;
            end
            p = bus.Clock_Muestreo;
        end
        if (!ok) chk("sclk_fall_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 * 2; i++) begin
            @(negedge Clock_Nexys);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", done_cnt, target);
    endtask

    task automatic run_frame(input logic [15:0] word);
        int n0;
        n0 = done_cnt;
        tx_q.push_back(word);
        wait_sclk_fall();
        bus.start = 1'b1;
        wait_done(n0 + 1);
        bus.start = 1'b0;
        chk("one_done_per_frame", done_cnt, n0 + 1);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int  n0;
        bit  ok;
        Reset      = 1'b0;
        reset_Clck = 1'b0;
        bus.start  = 1'b0;
        repeat (3) @(negedge Clock_Nexys);
        chk("hold_cs", bus.CS, 1'b1);
        chk("hold_sclk", bus.Clock_Muestreo, 1'b0);
        chk("hold_dato", bus.Dato, 12'h000);
        chk("hold_done", bus.done, 1'b0);
        chk("hold_basura", bus.data_basura, 4'h0);
        Reset      = 1'b1;
        reset_Clck = 1'b1;
        mon_en     = 1'b1;
        @(posedge Clock_Nexys);
        #1;
        chk("rel_cs", bus.CS, 1'b1);
        chk("rel_sclk", bus.Clock_Muestreo, 1'b0);
        chk("rel_dato", bus.Dato, 12'h000);
        chk("rel_done", bus.done, 1'b0);

        // 0000 then 1010... -> 0xAAA
        run_frame(16'h0AAA);
        chk("frame_aaa", bus.Dato, 12'hAAA);
        chk("frame_aaa_lead", bus.data_basura, 4'h0);
        repeat (5 * 2 * HP) @(negedge Clock_Nexys);
        chk("aaa_held", bus.Dato, 12'hAAA);

        run_frame(16'h0555);
        chk("frame_555", bus.Dato, 12'h555);

        run_frame(16'hBFFF);
        chk("lead_b", bus.data_basura, 4'hB);
        chk("lead_fff", bus.Dato, 12'hFFF);

        // Held start across two frames
        n0 = done_cnt;
        tx_q.push_back(16'h0123);
        tx_q.push_back(16'h0ABC);
        wait_sclk_fall();
        bus.start = 1'b1;
        wait_done(n0 + 2);
        bus.start = 1'b0;
        chk("held_two_done", done_cnt, n0 + 2);
        chk("held_last", bus.Dato, 12'hABC);
        repeat (4 * HP) @(negedge Clock_Nexys);

        // Reset at rising edge 8
        n0 = done_cnt;
        tx_q.push_back(16'h0FFF);
        wait_sclk_fall();
        bus.start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock_Nexys);
            if (in_frame && rises >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("edge8_timeout", rises, 8);
        Reset     = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("abort_cs", bus.CS, 1'b1);
        chk("abort_dato", bus.Dato, 12'h000);
        chk("abort_done", bus.done, 1'b0);
        repeat (4) @(negedge Clock_Nexys);
        Reset = 1'b1;
        repeat (2 * 2 * HP * 17) @(negedge Clock_Nexys);
        chk("abort_no_done", done_cnt, n0);
        run_frame(16'h0789);
        chk("after_abort", bus.Dato, 12'h789);

        repeat (30) @(negedge Clock_Nexys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
